wb_trace_unit: RTL and testbench

- Write-back trace producer for the 16-bit pipelined CPU.
- Captures every register-file write-back event at the end of the pipeline, buffers the events in a FIFO, and streams them out over a valid/ready interface.
- The consumer is a bench monitor or a debug port. It receives an ordered log of architectural register writes instead of probing pipeline internals each cycle.
- Sits beside the WB stage. It is observe-only and never stalls the CPU.

---
 rtl/wb_trace_unit.sv | 95 +++++++++
 tb/tb_wb_trace_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wb_trace_unit.sv
// Write-back trace producer: captures register-file write-back events into a
// first-word-fall-through FIFO and streams them out over valid/ready.
module wb_trace_unit #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic [1:0]               wb_reg_write,
    input  logic [3:0]               wb_dest,
    input  logic [15:0]              wb_data,
    input  logic [15:0]              wb_r0_data,
    input  logic [15:0]              wb_pc,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [35:0]              trace_data,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        dropped,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  dest;
        logic [15:0] data;
    } trace_ent_t;

    trace_ent_t           mem_q [DEPTH];
    trace_ent_t           last_q, last_d, ent_a, ent_b;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_b_ptr;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [DROP_W-1:0]    drop_q, drop_d, drop_base;
    logic [DROP_W+1:0]    drop_sum;
    logic [CW:0]          space;
    logic [1:0]           n_drop;
    logic                 pop, ev_a, ev_b, push_a, push_b;

    always_comb begin
        ent_a     = '{pc: wb_pc, dest: wb_dest, data: wb_data};
        ent_b     = '{pc: wb_pc, dest: 4'h0,    data: wb_r0_data};
        pop       = (count_q != '0) && trace_ready;
        // A pop this cycle frees its slot before the pushes are placed.
        space     = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
        ev_a      = trace_en & wb_reg_write[0];
        ev_b      = trace_en & wb_reg_write[1];
        push_a    = ev_a && (space != '0);
        push_b    = ev_b && (space > (CW+1)'(push_a));
        n_drop    = 2'(ev_a & ~push_a) + 2'(ev_b & ~push_b);
        wr_b_ptr  = wr_ptr_q + AW'(push_a);
        wr_ptr_d  = wr_ptr_q + AW'(push_a) + AW'(push_b);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
        last_d    = pop ? mem_q[rd_ptr_q] : last_q;
        // Clear is applied first so a same-cycle drop restarts the count from zero.
        drop_base = clr_ovf ? '0 : drop_q;
        drop_sum  = {2'b00, drop_base} + {{DROP_W{1'b0}}, n_drop};
        drop_d    = (drop_sum[DROP_W+1:DROP_W] != 2'b00) ? '1 : drop_sum[DROP_W-1:0];
        ovf_d     = (n_drop != 2'd0) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push_a) mem_q[wr_ptr_q] <= ent_a;
        if (push_b) mem_q[wr_b_ptr] <= ent_b;
    end

    assign trace_valid = (count_q != '0);
    assign trace_data  = trace_valid ? mem_q[rd_ptr_q] : last_q;
    assign trace_count = count_q;
    assign overflow    = ovf_q;
    assign dropped     = drop_q;
endmodule

// File: tb/tb_wb_trace_unit.sv
// Directed self-checking bench for wb_trace_unit (DEPTH=8, DROP_W=8).
module tb_wb_trace_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic [1:0]  wb_reg_write;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data, wb_r0_data, wb_pc;
    logic        trace_valid, trace_ready;
    logic [35:0] trace_data;
    logic [3:0]  trace_count;
    logic        overflow;
    logic [7:0]  dropped;
    logic        clr_ovf;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q [8];

    wb_trace_unit #(.DEPTH(8), .DROP_W(8)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en), .wb_reg_write(wb_reg_write),
        .wb_dest(wb_dest), .wb_data(wb_data), .wb_r0_data(wb_r0_data), .wb_pc(wb_pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .trace_count(trace_count), .overflow(overflow), .dropped(dropped), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [1:0] wr, input logic [15:0] pc, input logic [3:0] dest,
                      input logic [15:0] data, input logic [15:0] r0);
        wb_reg_write = wr; wb_pc = pc; wb_dest = dest; wb_data = data; wb_r0_data = r0;
        tick();
        wb_reg_write = 2'b00;
    endtask

    initial begin
        reset = 1'b1; trace_en = 1'b0; wb_reg_write = 2'b00; wb_dest = '0;
        wb_data = '0; wb_r0_data = '0; wb_pc = '0; trace_ready = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        chk("rst_valid", 36'(trace_valid), 36'd0);
        chk("rst_count", 36'(trace_count), 36'd0);
        chk("rst_data", trace_data, 36'd0);
        chk("rst_ovf", 36'(overflow), 36'd0);
        chk("rst_drop", 36'(dropped), 36'd0);
        reset = 1'b0;
        trace_en = 1'b1;
        tick();

        // Single write, then pop
        ev(2'b01, 16'h0010, 4'd3, 16'hBEEF, 16'h0);
        chk("single_valid", 36'(trace_valid), 36'd1);
        chk("single_data", trace_data, 36'h0010_3_BEEF);
        chk("single_count", 36'(trace_count), 36'd1);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        chk("pop_valid", 36'(trace_valid), 36'd0);
        chk("pop_count", 36'(trace_count), 36'd0);
        chk("empty_hold", trace_data, 36'h0010_3_BEEF);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        chk("ready_empty_cnt", 36'(trace_count), 36'd0);

        // Dual write ordering: A before B
        ev(2'b11, 16'h0020, 4'd5, 16'h0007, 16'h0003);
        chk("dual_count", 36'(trace_count), 36'd2);
        chk("dual_first", trace_data, 36'h0020_5_0007);
        trace_ready = 1'b1; tick();
        chk("dual_second", trace_data, 36'h0020_0_0003);
        chk("dual_cnt1", 36'(trace_count), 36'd1);
        tick(); trace_ready = 1'b0;
        chk("dual_cnt0", 36'(trace_count), 36'd0);

        // Fill: 7 singles then a dual (B dropped), then one more single (dropped)
        for (int i = 0; i < 7; i++)
            ev(2'b01, 16'h0100 + 16'(i), 4'(i), 16'hA000 + 16'(i), 16'h0);
        ev(2'b11, 16'h0200, 4'd9, 16'hD00D, 16'hFFFF);
        chk("fill_count", 36'(trace_count), 36'd8);
        chk("fill_ovf", 36'(overflow), 36'd1);
        chk("fill_drop1", 36'(dropped), 36'd1);
        ev(2'b01, 16'h0300, 4'd2, 16'hEEEE, 16'h0);
        chk("fill_drop2", 36'(dropped), 36'd2);
        chk("fill_count2", 36'(trace_count), 36'd8);

        // Full with simultaneous push and pop
        chk("full_head", trace_data, 36'h0100_0_A000);
        trace_ready = 1'b1;
        ev(2'b01, 16'h0400, 4'd1, 16'h4444, 16'h0);
        trace_ready = 1'b0;
        chk("pp_count", 36'(trace_count), 36'd8);
        chk("pp_drop", 36'(dropped), 36'd2);

        // Stall: head stable while not ready
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", trace_data, 36'h0101_1_A001);
            chk("stall_valid", 36'(trace_valid), 36'd1);
        end

        // Clear without drop; contents untouched
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("clr_ovf", 36'(overflow), 36'd0);
        chk("clr_drop", 36'(dropped), 36'd0);
        chk("clr_count", 36'(trace_count), 36'd8);

        // Drain all 8 in order
        for (int i = 0; i < 6; i++) exp_q[i] = {16'h0101 + 16'(i), 4'(i + 1), 16'hA001 + 16'(i)};
        exp_q[6] = 36'h0200_9_D00D;
        exp_q[7] = 36'h0400_1_4444;
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain", trace_data, exp_q[i]);
            tick();
        end
        trace_ready = 1'b0;
        chk("drain_count", 36'(trace_count), 36'd0);
        chk("drain_valid", 36'(trace_valid), 36'd0);

        // Refill, then drop coinciding with clear
        for (int i = 0; i < 4; i++)
            ev(2'b11, 16'h0500 + 16'(i), 4'd7, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
        chk("refill_count", 36'(trace_count), 36'd8);
        chk("refill_ovf", 36'(overflow), 36'd0);
        clr_ovf = 1'b1;
        ev(2'b01, 16'h0600, 4'd1, 16'h1111, 16'h0);
        clr_ovf = 1'b0;
        chk("clrdrop_ovf", 36'(overflow), 36'd1);
        chk("clrdrop_drop", 36'(dropped), 36'd1);

        // Saturation: 300 more drops
        for (int i = 0; i < 150; i++)
            ev(2'b11, 16'h0700, 4'd1, 16'h1, 16'h2);
        chk("sat_drop", 36'(dropped), 36'd255);
        chk("sat_count", 36'(trace_count), 36'd8);
        chk("sat_head", trace_data, 36'h0500_7_1000);

        // Async reset mid-stream with 4 entries buffered
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        trace_ready = 1'b0;
        chk("pre_rst_count", 36'(trace_count), 36'd4);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 36'(trace_valid), 36'd0);
        chk("arst_count", 36'(trace_count), 36'd0);
        chk("arst_data", trace_data, 36'd0);
        chk("arst_drop", 36'(dropped), 36'd0);
        chk("arst_ovf", 36'(overflow), 36'd0);
        tick();
        reset = 1'b0;

        // Capture disabled: nothing pushed, nothing dropped
        trace_en = 1'b0;
        ev(2'b11, 16'h0800, 4'd4, 16'h4, 16'h5);
        chk("dis_count", 36'(trace_count), 36'd0);
        chk("dis_valid", 36'(trace_valid), 36'd0);
        chk("dis_drop", 36'(dropped), 36'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
